dmem_unit: RTL and testbench
============================

// Module: dmem_unit
// PURPOSE
//   Data memory stage directly downstream of the cpu core's DMEM interface.
//   Consumes dm_addr, dm_data_w, dm_ena/dm_r/dm_w and the eight width flags.
//   Performs little-endian byte-lane stores into a word RAM and returns
//   sign- or zero-extended load data on dm_data in the same cycle.
//   Keeps sticky error status and saturating access counters for debug.
// PARAMETERS
//   ADDR_BASE   32'h10010000  byte address mapped to word 0 of the RAM
//   DEPTH_LOG2  11            RAM depth = 2**DEPTH_LOG2 words (2048 = 8 KiB)
//   CNT_W       16            width of the load and store counters
// PORTS
//   clk        in   1         clock; all state updates on posedge
//   rst        in   1         asynchronous reset, active-high
//   ena        in   1         global enable; when low, no state changes
//   dm_ena     in   1         access request
//   dm_r       in   1         read strobe
//   dm_w       in   1         write strobe
//   dm_addr    in   32        byte address
//   dm_data_w  in   32        store data; low byte/half used for sb/sh
//   sb_flag, sh_flag, sw_flag                  in  1 each   store width
//   lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag in 1 each load width/sign
//   dm_data    out  32        load result, combinational
//   misalign   out  1         sticky misaligned-access flag
//   range_err  out  1         sticky out-of-window / illegal-flag flag
//   err_addr   out  32        dm_addr of the first error since reset
//   ld_cnt     out  CNT_W     accepted loads, saturating
//   st_cnt     out  CNT_W     accepted stores, saturating
// BEHAVIOUR
//   - Reset values: misalign=0, range_err=0, err_addr=0, ld_cnt=0, st_cnt=0.
//     RAM contents are not reset; the bench preloads them via $readmemh or by stores.
//   - off = dm_addr - ADDR_BASE (32-bit wrap).
//   - In range iff off < 4*2**DEPTH_LOG2. Word index = off[DEPTH_LOG2+1:2]; lane = dm_addr[1:0].
//   - Legal flags: exactly one of the eight flags is set.
//     Store flags require dm_w; load flags require dm_r.
//   - Accepted access: dm_ena, legal flags, in range, aligned.
//   - Store: the RAM write happens at the posedge where ena=1. Latency is 1 clock.
//       sb writes lane; sh writes lanes {lane[1],0} and +1; sw writes all 4.
//       Byte 0 is RAM[7:0] (little-endian).
//   - Load is combinational (0-cycle) from the current RAM contents.
//       lb/lbu: sign/zero-extend the byte at lane.
//       lh/lhu: sign/zero-extend the half at lane[1].
//       lw: the whole word.
//   - dm_data = 0 when no accepted load is present (dm_ena=0, dm_r=0, error, or no load flag).
//   - Same-edge read/write of one word: the load sees the pre-edge value.
//   - Alignment: sh/lh/lhu need lane[0]=0; sw/lw need lane=0.
//     A violation suppresses the access (no write, dm_data=0).
//     At the edge, if ena=1, misalign is set.
//   - Out of range or illegal flags with dm_ena=1: access suppressed; range_err is set at the edge.
//   - err_addr loads dm_addr only when both sticky flags are currently 0 (first error wins).
//   - Both stickies can set on the same edge if both conditions hold.
//   - Counters increment by 1 per accepted access at the edge with ena=1, and hold at all-ones.
//   - ena=0: no RAM write, no status/counter update; dm_data still reflects the read.
//   - rst asserted mid-access: status and counters clear immediately; the in-flight store is dropped.
// CONFIGURATION
//   DMEM_ALIGN_CHK_EN defined: alignment rules above apply and misalign is live.
//   DMEM_ALIGN_CHK_EN undefined: misalign is tied 0.
//     Half accesses ignore dm_addr[0]; word accesses ignore dm_addr[1:0].
//     The access then proceeds normally.
// TESTING
//   1 sw 0xDEADBEEF @0x10010000, then lw @0x10010000 -> dm_data=0xDEADBEEF, st_cnt=1, ld_cnt=1.
//   2 sb 0x..7F @0x10010003; lb and lbu @0x10010003 -> 0x0000007F.
//     Then sb 0x80 and lb -> 0xFFFFFF80; lbu -> 0x00000080.
//   3 sh 0x8001 @0x10010006; lh -> 0xFFFF8001, lhu -> 0x00008001.
//     lw @0x10010004 -> 0x8001xxxx with the low half unchanged.
//   4 With _EN: lw @0x10010002 -> dm_data=0, misalign=1, err_addr=0x10010002.
//     A following sw @0x10010001 -> RAM unchanged, err_addr still 0x10010002.
//   5 sw @0x0FFFFFFC and @0x10012000 -> no write, range_err=1, counters unchanged.
//     Asserting rst mid-cycle -> all outputs back to 0 asynchronously.
//   6 Hold ena=0 and issue sw @0x10010000 -> the word is unchanged.
//     Force st_cnt to 0xFFFF via 65535 stores, then one more store -> st_cnt stays 0xFFFF.

Source files
------------

// File: rtl/dmem_unit.sv
// Data memory stage: little-endian byte-lane word RAM with combinational loads,
// sticky error status and saturating access counters. Define DMEM_ALIGN_CHK_EN to enforce alignment.
module dmem_unit #(
  parameter logic [31:0] ADDR_BASE  = 32'h10010000,
  parameter int          DEPTH_LOG2 = 11,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              dm_ena,
  input  logic              dm_r,
  input  logic              dm_w,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_data_w,
  input  logic              sb_flag,
  input  logic              sh_flag,
  input  logic              sw_flag,
  input  logic              lb_flag,
  input  logic              lh_flag,
  input  logic              lbu_flag,
  input  logic              lhu_flag,
  input  logic              lw_flag,
  output logic [31:0]       dm_data,
  output logic              misalign,
  output logic              range_err,
  output logic [31:0]       err_addr,
  output logic [CNT_W-1:0]  ld_cnt,
  output logic [CNT_W-1:0]  st_cnt
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

  function automatic logic one_hot8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return (c == 4'd1);
  endfunction

  logic [31:0]           mem [0:DEPTH-1];

  logic [31:0]           off_s;
  logic                  in_range_s;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [1:0]            lane_s;
  logic [7:0]            flags_s;
  logic                  st_flag_s;
  logic                  ld_flag_s;
  logic                  legal_s;
  logic                  mis_s;
  logic                  acc_s;
  logic                  st_acc_s;
  logic                  ld_acc_s;
  logic                  mis_err_s;
  logic                  rng_err_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_s;
  logic [31:0]           rd_word_s;
  logic [7:0]            rd_byte_s;
  logic [15:0]           rd_half_s;
  logic [31:0]           load_s;

  logic                  misalign_r;
  logic                  range_err_r;
  logic [31:0]           err_addr_r;
  logic [CNT_W-1:0]      ld_cnt_r;
  logic [CNT_W-1:0]      st_cnt_r;

  assign off_s      = dm_addr - ADDR_BASE;
  assign in_range_s = (off_s < WIN_BYTES);
  assign idx_s      = off_s[DEPTH_LOG2+1:2];
  assign lane_s     = dm_addr[1:0];

  assign flags_s   = {sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag};
  assign st_flag_s = sb_flag | sh_flag | sw_flag;
  assign ld_flag_s = lb_flag | lh_flag | lbu_flag | lhu_flag | lw_flag;
  assign legal_s   = one_hot8(flags_s) && ((st_flag_s && dm_w) || (ld_flag_s && dm_r));

`ifdef DMEM_ALIGN_CHK_EN
  assign mis_s = ((sh_flag | lh_flag | lhu_flag) & lane_s[0]) |
                 ((sw_flag | lw_flag) & (lane_s != 2'd0));
`else
  // Half and word accesses simply drop the low address bits they cannot use.
  assign mis_s = 1'b0;
`endif

  assign acc_s     = dm_ena && legal_s && in_range_s && !mis_s;
  assign st_acc_s  = acc_s && st_flag_s;
  assign ld_acc_s  = acc_s && ld_flag_s;
  assign mis_err_s = dm_ena && mis_s;
  assign rng_err_s = dm_ena && (!legal_s || !in_range_s);

  // Byte enables and lane-replicated write data for the store width
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'd0;
    if (sb_flag) begin
      be_s    = 4'b0001 << lane_s;
      wdata_s = {4{dm_data_w[7:0]}};
    end else if (sh_flag) begin
      be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
      wdata_s = {2{dm_data_w[15:0]}};
    end else if (sw_flag) begin
      be_s    = 4'b1111;
      wdata_s = dm_data_w;
    end else begin
      be_s    = 4'b0000;
      wdata_s = 32'd0;
    end
  end

  // RAM write port; contents are intentionally not reset, a store under reset is dropped
  always_ff @(posedge clk) begin
    if (!rst && ena && st_acc_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign rd_word_s = mem[idx_s];

  // Lane selection for byte and half loads
  always_comb begin
    rd_byte_s = 8'd0;
    case (lane_s)
      2'd0:    rd_byte_s = rd_word_s[7:0];
      2'd1:    rd_byte_s = rd_word_s[15:8];
      2'd2:    rd_byte_s = rd_word_s[23:16];
      2'd3:    rd_byte_s = rd_word_s[31:24];
      default: rd_byte_s = 8'd0;
    endcase
    if (lane_s[1]) begin
      rd_half_s = rd_word_s[31:16];
    end else begin
      rd_half_s = rd_word_s[15:0];
    end
  end

  // Sign/zero extension; anything but an accepted load reads as zero
  always_comb begin
    load_s = 32'd0;
    if (ld_acc_s) begin
      if (lb_flag) begin
        load_s = {{24{rd_byte_s[7]}}, rd_byte_s};
      end else if (lbu_flag) begin
        load_s = {24'd0, rd_byte_s};
      end else if (lh_flag) begin
        load_s = {{16{rd_half_s[15]}}, rd_half_s};
      end else if (lhu_flag) begin
        load_s = {16'd0, rd_half_s};
      end else if (lw_flag) begin
        load_s = rd_word_s;
      end else begin
        load_s = 32'd0;
      end
    end else begin
      load_s = 32'd0;
    end
  end

  // Sticky error status; err_addr latches only the first error after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_r  <= 1'b0;
      range_err_r <= 1'b0;
      err_addr_r  <= 32'd0;
    end else if (ena) begin
      if (mis_err_s) begin
        misalign_r <= 1'b1;
      end
      if (rng_err_s) begin
        range_err_r <= 1'b1;
      end
      if ((mis_err_s || rng_err_s) && !misalign_r && !range_err_r) begin
        err_addr_r <= dm_addr;
      end
    end
  end

  // Saturating load/store counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt_r <= '0;
      st_cnt_r <= '0;
    end else if (ena) begin
      if (ld_acc_s && (ld_cnt_r != '1)) begin
        ld_cnt_r <= ld_cnt_r + CNT_W'(1);
      end
      if (st_acc_s && (st_cnt_r != '1)) begin
        st_cnt_r <= st_cnt_r + CNT_W'(1);
      end
    end
  end

  assign dm_data   = load_s;
  assign misalign  = misalign_r;
  assign range_err = range_err_r;
  assign err_addr  = err_addr_r;
  assign ld_cnt    = ld_cnt_r;
  assign st_cnt    = st_cnt_r;

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_dmem_unit;

  localparam logic [7:0] F_SB  = 8'h80;
  localparam logic [7:0] F_SH  = 8'h40;
  localparam logic [7:0] F_SW  = 8'h20;
  localparam logic [7:0] F_LB  = 8'h10;
  localparam logic [7:0] F_LH  = 8'h08;
  localparam logic [7:0] F_LBU = 8'h04;
  localparam logic [7:0] F_LHU = 8'h02;
  localparam logic [7:0] F_LW  = 8'h01;

  localparam int S_DATA = 0;
  localparam int S_MIS  = 1;
  localparam int S_RNG  = 2;
  localparam int S_EA   = 3;
  localparam int S_LD   = 4;
  localparam int S_ST   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        dm_ena;
  logic        dm_r;
  logic        dm_w;
  logic [31:0] dm_addr;
  logic [31:0] dm_data_w;
  logic [7:0]  flags;
  logic [31:0] dm_data;
  logic        misalign;
  logic        range_err;
  logic [31:0] err_addr;
  logic [15:0] ld_cnt;
  logic [15:0] st_cnt;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_unit dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .dm_ena    (dm_ena),
    .dm_r      (dm_r),
    .dm_w      (dm_w),
    .dm_addr   (dm_addr),
    .dm_data_w (dm_data_w),
    .sb_flag   (flags[7]),
    .sh_flag   (flags[6]),
    .sw_flag   (flags[5]),
    .lb_flag   (flags[4]),
    .lh_flag   (flags[3]),
    .lbu_flag  (flags[2]),
    .lhu_flag  (flags[1]),
    .lw_flag   (flags[0]),
    .dm_data   (dm_data),
    .misalign  (misalign),
    .range_err (range_err),
    .err_addr  (err_addr),
    .ld_cnt    (ld_cnt),
    .st_cnt    (st_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the outputs presented at this negedge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      automatic exp_t e = q.pop_front();
      automatic logic [31:0] act;
      case (e.sel)
        S_DATA:  act = dm_data;
        S_MIS:   act = {31'd0, misalign};
        S_RNG:   act = {31'd0, range_err};
        S_EA:    act = err_addr;
        S_LD:    act = {16'd0, ld_cnt};
        S_ST:    act = {16'd0, st_cnt};
        default: act = 32'hxxxxxxxx;
      endcase
      n_cmp = n_cmp + 1;
      if (act !== e.val) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic expect_status(input string tag, input logic mis, input logic rng,
                               input logic [31:0] ea, input logic [15:0] ld, input logic [15:0] st);
    expect_val({tag, ".misalign"},  S_MIS, {31'd0, mis});
    expect_val({tag, ".range_err"}, S_RNG, {31'd0, rng});
    expect_val({tag, ".err_addr"},  S_EA,  ea);
    expect_val({tag, ".ld_cnt"},    S_LD,  {16'd0, ld});
    expect_val({tag, ".st_cnt"},    S_ST,  {16'd0, st});
  endtask

  task automatic idle();
    dm_ena    = 1'b0;
    dm_r      = 1'b0;
    dm_w      = 1'b0;
    dm_addr   = 32'd0;
    dm_data_w = 32'd0;
    flags     = 8'd0;
  endtask

  // One access held for a full cycle; load data is checked while it is presented
  task automatic access(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [7:0] f, input logic r, input logic w,
                        input logic chk, input logic [31:0] exp_data);
    @(posedge clk);
    #1;
    dm_ena    = 1'b1;
    dm_r      = r;
    dm_w      = w;
    dm_addr   = addr;
    dm_data_w = wd;
    flags     = f;
    if (chk) expect_val({tag, ".dm_data"}, S_DATA, exp_data);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] f);
    access(tag, addr, wd, f, 1'b0, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [7:0] f, input logic [31:0] exp_data);
    access(tag, addr, 32'd0, f, 1'b1, 1'b0, 1'b1, exp_data);
  endtask

  logic        mis_e;
  logic [31:0] ea4_e;
  logic [31:0] ea5_e;
  logic [31:0] w0_e;
  logic [31:0] w2_e;
  logic [15:0] ld4_e;
  logic [15:0] st4_e;

  initial begin
`ifdef DMEM_ALIGN_CHK_EN
    mis_e = 1'b1; ea4_e = 32'h10010002; ea5_e = 32'h10010002;
    w2_e  = 32'h00000000; w0_e = 32'h80ADBEEF; ld4_e = 16'd10; st4_e = 16'd5;
`else
    mis_e = 1'b0; ea4_e = 32'h00000000; ea5_e = 32'h0FFFFFFC;
    w2_e  = 32'h80ADBEEF; w0_e = 32'h55555555; ld4_e = 16'd11; st4_e = 16'd6;
`endif
    rst = 1'b1;
    ena = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    expect_status("reset", 1'b0, 1'b0, 32'd0, 16'd0, 16'd0);
    rst = 1'b0;

    // 1: word store then load
    store("t1_sw", 32'h10010000, 32'hDEADBEEF, F_SW);
    load("t1_lw", 32'h10010000, F_LW, 32'hDEADBEEF);
    expect_status("t1", 1'b0, 1'b0, 32'd0, 16'd1, 16'd1);

    // 2: byte stores with sign/zero extension
    store("t2_sb7f", 32'h10010003, 32'h1234567F, F_SB);
    load("t2_lb7f",  32'h10010003, F_LB,  32'h0000007F);
    load("t2_lbu7f", 32'h10010003, F_LBU, 32'h0000007F);
    store("t2_sb80", 32'h10010003, 32'hAAAAAA80, F_SB);
    load("t2_lb80",  32'h10010003, F_LB,  32'hFFFFFF80);
    load("t2_lbu80", 32'h10010003, F_LBU, 32'h00000080);
    load("t2_lw",    32'h10010000, F_LW,  32'h80ADBEEF);
    expect_status("t2", 1'b0, 1'b0, 32'd0, 16'd6, 16'd3);

    // 3: upper half store leaves the low half intact
    store("t3_sw", 32'h10010004, 32'h11223344, F_SW);
    store("t3_sh", 32'h10010006, 32'hFFFF8001, F_SH);
    load("t3_lh",  32'h10010006, F_LH,  32'hFFFF8001);
    load("t3_lhu", 32'h10010006, F_LHU, 32'h00008001);
    load("t3_lw",  32'h10010004, F_LW,  32'h80013344);
    expect_status("t3", 1'b0, 1'b0, 32'd0, 16'd9, 16'd5);

    // 4: misaligned word accesses
    load("t4_lw02", 32'h10010002, F_LW, w2_e);
    store("t4_sw01", 32'h10010001, 32'h55555555, F_SW);
    load("t4_lw00", 32'h10010000, F_LW, w0_e);
    expect_status("t4", mis_e, 1'b0, ea4_e, ld4_e, st4_e);

    // 5: window edges and illegal flag combinations
    store("t5_lo", 32'h0FFFFFFC, 32'h01010101, F_SW);
    store("t5_hi", 32'h10012000, 32'h02020202, F_SW);
    expect_status("t5a", mis_e, 1'b1, ea5_e, ld4_e, st4_e);
    access("t5_lw_nor", 32'h10010000, 32'd0, F_LW, 1'b0, 1'b1, 1'b1, 32'd0);
    access("t5_2flag", 32'h10010000, 32'd0, F_LW | F_SW, 1'b1, 1'b1, 1'b1, 32'd0);
    store("t5_last", 32'h10011FFC, 32'hCAFEF00D, F_SW);
    load("t5_last", 32'h10011FFC, F_LW, 32'hCAFEF00D);
    expect_status("t5b", mis_e, 1'b1, ea5_e, ld4_e + 16'd1, st4_e + 16'd1);

    // Reset pulse between edges must clear status asynchronously
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_status("rst_async", 1'b0, 1'b0, 32'd0, 16'd0, 16'd0);
    expect_val("rst_async.dm_data", S_DATA, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // 6: ena low freezes RAM and counters but loads still read
    ena = 1'b0;
    store("t6_sw_off", 32'h10010000, 32'h00000000, F_SW);
    load("t6_lw_off", 32'h10010000, F_LW, w0_e);
    store("t6_bad_off", 32'h10012000, 32'h0, F_SW);
    expect_status("t6_off", 1'b0, 1'b0, 32'd0, 16'd0, 16'd0);
    ena = 1'b1;
    load("t6_lw_on", 32'h10010000, F_LW, w0_e);
    expect_status("t6_on", 1'b0, 1'b0, 32'd0, 16'd1, 16'd0);

    // Store counter saturation
    @(posedge clk);
    #1;
    dm_ena    = 1'b1;
    dm_w      = 1'b1;
    dm_addr   = 32'h10010010;
    dm_data_w = 32'h0;
    flags     = F_SW;
    repeat (65535) @(posedge clk);
    #1;
    expect_val("sat.st_full", S_ST, 32'h0000FFFF);
    @(posedge clk);
    #1;
    idle();
    expect_status("sat_hold", 1'b0, 1'b0, 32'd0, 16'd1, 16'hFFFF);

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
